// File: rtl/machine_ram_arbiter.sv
// Round-robin arbiter sharing the single Machine_ram port between N requesters.
// One request in flight at a time; read responses routed back to the owner.
module machine_ram_arbiter #(
  parameter int N       = 2,
  parameter int TIMEOUT = 15
) (
  input  logic            system1000,
  input  logic            system1000_rst,
  input  logic [N*96-1:0] reqs,
  output logic [N-1:0]    req_ready,
  output logic [N*66-1:0] rsps,
  output logic [95:0]     ram_req,
  input  logic [65:0]     ram_rsp
);

  localparam int PW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_rr_ptr;
  logic [PW-1:0]   r_owner;
  logic [7:0]      r_timer;
  logic [95:0]     r_ram_req;
  logic [N*66-1:0] r_rsps;

  logic            w_found;
  logic [PW-1:0]   w_win;
  logic [PW-1:0]   w_rr_nxt;
  logic [95:0]     w_win_req;
  logic            w_tmo;

  // Scan from rr_ptr upward, wrapping explicitly since N may not be 2^k.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_found) begin
        idx = int'(r_rr_ptr) + k;
        if (idx >= N) idx = idx - N;
        if (reqs[96*idx+95]) begin
          w_found = 1'b1;
          w_win   = PW'(idx);
        end
      end
    end
  end

  always_comb begin
    w_win_req = reqs[96*int'(w_win) +: 96];
    w_rr_nxt  = (w_win == PW'(N-1)) ? '0 : w_win + PW'(1);
    w_tmo     = (r_timer == 8'(TIMEOUT-1));
  end

  always_comb begin
    req_ready = '0;
    if (!system1000_rst && r_state == S_IDLE && w_found)
      req_ready = N'(1) << w_win;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_found) w_next = S_ISSUE;
      S_ISSUE: w_next = r_ram_req[94] ? S_IDLE : S_WAIT;
      S_WAIT:  if (ram_rsp[65] || w_tmo) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_owner   <= '0;
      r_timer   <= '0;
      r_ram_req <= '0;
      r_rsps    <= '0;
    end else begin
      r_state <= w_next;
      r_rsps  <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_ram_req <= {1'b1, w_win_req[94:0]};
            r_owner   <= w_win;
            r_rr_ptr  <= w_rr_nxt;
          end else begin
            r_ram_req <= '0;
          end
        end
        S_ISSUE: begin
          r_ram_req <= '0;
          r_timer   <= '0;
        end
        S_WAIT: begin
          if (ram_rsp[65])
            r_rsps[66*int'(r_owner) +: 66] <= {1'b1, ram_rsp[64:0]};
          else if (w_tmo)
            r_rsps[66*int'(r_owner) +: 66] <= {2'b11, 64'd0};
          else
            r_timer <= r_timer + 8'd1;
        end
        default: r_ram_req <= '0;
      endcase
    end
  end

  assign ram_req = r_ram_req;
  assign rsps    = r_rsps;

endmodule

// File: tb/tb_machine_ram_arbiter.sv
// Directed bench: instance A (N=2, TIMEOUT=15), instance B (N=3, TIMEOUT=4).
module tb_machine_ram_arbiter;

  logic          clk = 1'b0;
  logic          rst = 1'b0;

  logic [191:0]  reqs_a = '0;
  logic [1:0]    rdy_a;
  logic [131:0]  rsps_a;
  logic [95:0]   ramq_a;
  logic [65:0]   ramr_a = '0;

  logic [287:0]  reqs_b = '0;
  logic [2:0]    rdy_b;
  logic [197:0]  rsps_b;
  logic [95:0]   ramq_b;
  logic [65:0]   ramr_b = '0;

  int pass_n = 0;
  int tot_n  = 0;

  always #5 clk = ~clk;

  machine_ram_arbiter #(.N(2), .TIMEOUT(15)) u_a (
    .system1000     (clk),
    .system1000_rst (rst),
    .reqs           (reqs_a),
    .req_ready      (rdy_a),
    .rsps           (rsps_a),
    .ram_req        (ramq_a),
    .ram_rsp        (ramr_a)
  );

  machine_ram_arbiter #(.N(3), .TIMEOUT(4)) u_b (
    .system1000     (clk),
    .system1000_rst (rst),
    .reqs           (reqs_b),
    .req_ready      (rdy_b),
    .rsps           (rsps_b),
    .ram_req        (ramq_b),
    .ram_rsp        (ramr_b)
  );

  function automatic logic [95:0] mk(input logic w, input logic [29:0] p,
                                     input logic [63:0] d);
    return {1'b1, w, p, d};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    reqs_a[95:0] = mk(1'b0, 30'h1, 64'h0);
    reqs_b[95:0] = mk(1'b0, 30'h1, 64'h0);
    cyc();
    cyc();
    #2;
    tot_n++;
    if (rdy_a !== 2'b00) $display("FAIL rst_rdy_a got %b exp 00", rdy_a);
    else pass_n++;
    tot_n++;
    if (rdy_b !== 3'b000) $display("FAIL rst_rdy_b got %b exp 000", rdy_b);
    else pass_n++;
    tot_n++;
    if (ramq_a !== 96'd0) $display("FAIL rst_ramq got %h exp 0", ramq_a);
    else pass_n++;
    tot_n++;
    if (rsps_a !== 132'd0) $display("FAIL rst_rsps got %h exp 0", rsps_a);
    else pass_n++;
    reqs_a = '0;
    reqs_b = '0;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_single_read();
    reqs_a[95:0] = mk(1'b0, 30'h5, 64'h0);
    #2;
    tot_n++;
    if (rdy_a !== 2'b01) $display("FAIL rd_ready got %b exp 01", rdy_a);
    else pass_n++;
    tot_n++;
    if (ramq_a !== 96'd0) $display("FAIL rd_ramq_t got %h exp 0", ramq_a);
    else pass_n++;
    cyc();
    reqs_a = '0;
    #2;
    tot_n++;
    if (ramq_a !== {1'b1, 1'b0, 30'h5, 64'h0})
      $display("FAIL rd_ramq_t1 got %h exp %h", ramq_a,
               {1'b1, 1'b0, 30'h5, 64'h0});
    else pass_n++;
    cyc();
    ramr_a = {1'b1, 1'b0, 64'hDEADBEEF};
    #2;
    tot_n++;
    if (ramq_a !== 96'd0) $display("FAIL rd_ramq_t2 got %h exp 0", ramq_a);
    else pass_n++;
    tot_n++;
    if (rsps_a !== 132'd0) $display("FAIL rd_rsps_t2 got %h exp 0", rsps_a);
    else pass_n++;
    cyc();
    ramr_a = '0;
    #2;
    tot_n++;
    if (rsps_a[65:0] !== {1'b1, 1'b0, 64'hDEADBEEF})
      $display("FAIL rd_rsp0 got %h exp %h", rsps_a[65:0],
               {1'b1, 1'b0, 64'hDEADBEEF});
    else pass_n++;
    tot_n++;
    if (rsps_a[131:66] !== 66'd0)
      $display("FAIL rd_rsp1 got %h exp 0", rsps_a[131:66]);
    else pass_n++;
    cyc();
    #2;
    tot_n++;
    if (rsps_a !== 132'd0) $display("FAIL rd_rsp_pulse got %h exp 0", rsps_a);
    else pass_n++;
  endtask

  // rr_ptr is 1 after the single read, so grants run 1,0,1,0.
  task automatic test_round_robin();
    logic [29:0] ptr [2];
    int          w;
    ptr[0] = 30'h100;
    ptr[1] = 30'h200;
    reqs_a[95:0]   = mk(1'b1, ptr[0], 64'(ptr[0]));
    reqs_a[191:96] = mk(1'b1, ptr[1], 64'(ptr[1]));
    for (int g = 0; g < 4; g++) begin
      w = (g % 2 == 0) ? 1 : 0;
      #2;
      tot_n++;
      if (rdy_a !== (2'b01 << w))
        $display("FAIL rr_grant%0d got %b exp %b", g, rdy_a, 2'b01 << w);
      else pass_n++;
      cyc();
      #2;
      tot_n++;
      if (ramq_a !== mk(1'b1, ptr[w], 64'(ptr[w])))
        $display("FAIL rr_ramq%0d got %h exp %h", g, ramq_a,
                 mk(1'b1, ptr[w], 64'(ptr[w])));
      else pass_n++;
      tot_n++;
      if (rsps_a !== 132'd0) $display("FAIL rr_rsps%0d got %h exp 0", g, rsps_a);
      else pass_n++;
      ptr[w] = ptr[w] + 30'd1;
      reqs_a[96*w +: 96] = mk(1'b1, ptr[w], 64'(ptr[w]));
      if (g == 3) reqs_a = '0;
      cyc();
    end
  endtask

  task automatic test_fault_passthrough();
    reqs_a[191:96] = mk(1'b0, 30'h7, 64'h0);
    #2;
    tot_n++;
    if (rdy_a !== 2'b10) $display("FAIL flt_ready got %b exp 10", rdy_a);
    else pass_n++;
    cyc();
    reqs_a = '0;
    cyc();
    cyc();
    ramr_a = {1'b1, 1'b1, 64'h7};
    cyc();
    ramr_a = '0;
    #2;
    tot_n++;
    if (rsps_a[131:66] !== {1'b1, 1'b1, 64'h7})
      $display("FAIL flt_rsp1 got %h exp %h", rsps_a[131:66],
               {1'b1, 1'b1, 64'h7});
    else pass_n++;
    tot_n++;
    if (rsps_a[65:0] !== 66'd0)
      $display("FAIL flt_rsp0 got %h exp 0", rsps_a[65:0]);
    else pass_n++;
    cyc();
  endtask

  // rr_ptr is 0 here; after granting 0 it is 1, reset must bring it back to 0.
  task automatic test_reset_mid_wait();
    reqs_a[95:0] = mk(1'b0, 30'h9, 64'h0);
    #2;
    tot_n++;
    if (rdy_a !== 2'b01) $display("FAIL rmw_ready got %b exp 01", rdy_a);
    else pass_n++;
    cyc();
    reqs_a = '0;
    cyc();
    cyc();
    rst = 1'b1;
    ramr_a = {1'b1, 1'b0, 64'h55};
    cyc();
    rst = 1'b0;
    #2;
    tot_n++;
    if (ramq_a !== 96'd0 || rsps_a !== 132'd0 || rdy_a !== 2'b00)
      $display("FAIL rmw_outs got ramq=%h rsps=%h rdy=%b exp 0", ramq_a,
               rsps_a, rdy_a);
    else pass_n++;
    cyc();
    ramr_a = '0;
    #2;
    tot_n++;
    if (rsps_a !== 132'd0) $display("FAIL rmw_ignored got %h exp 0", rsps_a);
    else pass_n++;
    reqs_a[95:0]   = mk(1'b1, 30'h11, 64'h1);
    reqs_a[191:96] = mk(1'b1, 30'h22, 64'h2);
    #2;
    tot_n++;
    if (rdy_a !== 2'b01) $display("FAIL rmw_rrptr got %b exp 01", rdy_a);
    else pass_n++;
    cyc();
    reqs_a = '0;
    cyc();
  endtask

  task automatic test_wrap();
    reqs_b[191:96] = mk(1'b1, 30'h31, 64'h0);
    #2;
    tot_n++;
    if (rdy_b !== 3'b010) $display("FAIL wrap_g1 got %b exp 010", rdy_b);
    else pass_n++;
    cyc();
    reqs_b = '0;
    #2;
    tot_n++;
    if (ramq_b !== mk(1'b1, 30'h31, 64'h0))
      $display("FAIL wrap_ramq got %h exp %h", ramq_b, mk(1'b1, 30'h31, 64'h0));
    else pass_n++;
    cyc();
    reqs_b[95:0]   = mk(1'b1, 30'h40, 64'h0);
    reqs_b[191:96] = mk(1'b1, 30'h41, 64'h0);
    #2;
    tot_n++;
    if (rdy_b !== 3'b001) $display("FAIL wrap_g0 got %b exp 001", rdy_b);
    else pass_n++;
    cyc();
    reqs_b = '0;
    cyc();
    reqs_b[95:0]    = mk(1'b1, 30'h50, 64'h0);
    reqs_b[191:96]  = mk(1'b1, 30'h51, 64'h0);
    reqs_b[287:192] = mk(1'b1, 30'h52, 64'h0);
    #2;
    tot_n++;
    if (rdy_b !== 3'b010) $display("FAIL wrap_ptr1 got %b exp 010", rdy_b);
    else pass_n++;
    cyc();
    reqs_b = '0;
    cyc();
  endtask

  // rr_ptr is 2 here; requester 2 reads and the RAM never answers.
  task automatic test_timeout();
    reqs_b[287:192] = mk(1'b0, 30'h3, 64'h0);
    #2;
    tot_n++;
    if (rdy_b !== 3'b100) $display("FAIL tmo_ready got %b exp 100", rdy_b);
    else pass_n++;
    cyc();
    reqs_b = '0;
    for (int k = 2; k < 6; k++) begin
      cyc();
      #2;
      tot_n++;
      if (rsps_b !== 198'd0)
        $display("FAIL tmo_early_t%0d got %h exp 0", k, rsps_b);
      else pass_n++;
    end
    cyc();
    #2;
    tot_n++;
    if (rsps_b[197:132] !== {2'b11, 64'd0})
      $display("FAIL tmo_fault got %h exp %h", rsps_b[197:132], {2'b11, 64'd0});
    else pass_n++;
    tot_n++;
    if (rsps_b[131:0] !== 132'd0)
      $display("FAIL tmo_others got %h exp 0", rsps_b[131:0]);
    else pass_n++;
    cyc();
    ramr_b = {1'b1, 1'b0, 64'h99};
    cyc();
    ramr_b = '0;
    #2;
    tot_n++;
    if (rsps_b !== 198'd0) $display("FAIL tmo_late got %h exp 0", rsps_b);
    else pass_n++;
    reqs_b[95:0] = mk(1'b1, 30'h60, 64'h0);
    #2;
    tot_n++;
    if (rdy_b !== 3'b001) $display("FAIL tmo_idle got %b exp 001", rdy_b);
    else pass_n++;
    cyc();
    reqs_b = '0;
    cyc();
  endtask

  initial begin
    cyc();
    test_reset();
    test_single_read();
    test_round_robin();
    test_fault_passthrough();
    test_reset_mid_wait();
    test_wrap();
    test_timeout();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
